// File: rtl/cache_arbiter.sv
// Two-client line-fill/write-back arbiter between an I-cache and a D-cache
// sharing one physical-memory port; round-robin on simultaneous requests.
module cache_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t            state_q;
    logic              last_dc_q;
    logic              gnt_dc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic              iresp_q;
    logic              dresp_q;

    logic              dreq_d;
    logic              gnt_dc_d;
    logic              wr_d;

    // On a tie the D-cache wins only if the I-cache was served last.
    always_comb begin
        dreq_d   = dcache_read | dcache_write;
        gnt_dc_d = dreq_d & (~icache_read | ~last_dc_q);
        wr_d     = gnt_dc_d & dcache_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_dc_q    <= 1'b1;
            gnt_dc_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            iresp_q      <= 1'b0;
            dresp_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    iresp_q <= 1'b0;
                    dresp_q <= 1'b0;
                    if (icache_read | dreq_d) begin
                        gnt_dc_q     <= gnt_dc_d;
                        last_dc_q    <= gnt_dc_d;
                        addr_q       <= gnt_dc_d ? dcache_address : icache_address;
                        wdata_q      <= gnt_dc_d ? dcache_wdata : '0;
                        pmem_read_q  <= ~wr_d;
                        pmem_write_q <= wr_d;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        line_q       <= pmem_rdata;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        iresp_q      <= ~gnt_dc_q;
                        dresp_q      <= gnt_dc_q;
                        state_q      <= RESPOND;
                    end
                end
                RESPOND: begin
                    iresp_q <= 1'b0;
                    dresp_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                    iresp_q      <= 1'b0;
                    dresp_q      <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign icache_resp  = iresp_q;
    assign dcache_resp  = dresp_q;
    assign icache_rdata = line_q;
    assign dcache_rdata = line_q;

endmodule
